// File: rtl/mdu.sv
// mdu: multiply/divide unit for the execute stage. Owns HI/LO, runs
// MULT/MULTU/DIV/DIVU with a fixed busy period, and handles MTHI/MTLO.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        readHi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] readData
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [3:0]  r_cnt;
    op_e         r_cls;

    op_e         w_op;
    logic        w_accept;
    logic [63:0] w_extA;
    logic [63:0] w_extB;
    logic [63:0] w_prod;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [31:0] w_divS;
    logic [31:0] w_divU;
    logic [31:0] w_qMag;
    logic [31:0] w_rMag;
    logic [31:0] w_qU;
    logic [31:0] w_rU;
    logic [31:0] w_resHi;
    logic [31:0] w_resLo;
    logic        w_commitOk;

    assign w_op     = op_e'(op);
    assign busy     = (r_cnt != 4'd0);
    assign w_accept = start & ~flush & ~busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign readData = readHi ? r_hi : r_lo;

    // Result datapath from latched operands; signed divide is done on
    // magnitudes so 0x80000000 / -1 falls out naturally without overflow.
    always_comb begin
        w_extA     = '0;
        w_extB     = '0;
        w_prod     = '0;
        w_absA     = r_opA[31] ? (32'd0 - r_opA) : r_opA;
        w_absB     = r_opB[31] ? (32'd0 - r_opB) : r_opB;
        w_divS     = (w_absB == 32'd0) ? 32'd1 : w_absB;
        w_divU     = (r_opB == 32'd0) ? 32'd1 : r_opB;
        w_qMag     = w_absA / w_divS;
        w_rMag     = w_absA % w_divS;
        w_qU       = r_opA / w_divU;
        w_rU       = r_opA % w_divU;
        w_resHi    = r_hi;
        w_resLo    = r_lo;
        w_commitOk = 1'b1;
        if (r_cls == OP_MULT) begin
            w_extA = {{32{r_opA[31]}}, r_opA};
            w_extB = {{32{r_opB[31]}}, r_opB};
        end else begin
            w_extA = {32'd0, r_opA};
            w_extB = {32'd0, r_opB};
        end
        w_prod = w_extA * w_extB;
        case (r_cls)
            OP_MULT, OP_MULTU: begin
                w_resHi = w_prod[63:32];
                w_resLo = w_prod[31:0];
            end
            OP_DIV: begin
                w_resLo    = (r_opA[31] ^ r_opB[31]) ? (32'd0 - w_qMag) : w_qMag;
                w_resHi    = r_opA[31] ? (32'd0 - w_rMag) : w_rMag;
                w_commitOk = (r_opB != 32'd0);
            end
            OP_DIVU: begin
                w_resLo    = w_qU;
                w_resHi    = w_rU;
                w_commitOk = (r_opB != 32'd0);
            end
            default: w_commitOk = 1'b0;
        endcase
    end

    // Busy counter, operand latch, HI/LO commit and MTHI/MTLO writes.
    // Accept requires ~busy, so an MTHI/MTLO never collides with a commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_cnt <= '0;
            r_opA <= '0;
            r_opB <= '0;
            r_cls <= OP_NONE;
        end else begin
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_cnt == 4'd1 && w_commitOk) begin
                r_hi <= w_resHi;
                r_lo <= w_resLo;
            end
            if (w_accept) begin
                case (w_op)
                    OP_MULT, OP_MULTU: begin
                        r_opA <= srcA;
                        r_opB <= srcB;
                        r_cls <= w_op;
                        r_cnt <= 4'(MULT_CYCLES);
                    end
                    OP_DIV, OP_DIVU: begin
                        r_opA <= srcA;
                        r_opB <= srcB;
                        r_cls <= w_op;
                        r_cnt <= 4'(DIV_CYCLES);
                    end
                    OP_MTHI: r_hi <= srcA;
                    OP_MTLO: r_lo <= srcA;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed plus random checks of mdu against an arithmetic model.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        readHi;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] readData;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
        .srcA(srcA), .srcB(srcB), .readHi(readHi), .busy(busy),
        .hi(hi), .lo(lo), .readData(readData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one op given the previous HI/LO.
    task automatic ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ohi, input logic [31:0] olo,
                          output logic [31:0] nhi, output logic [31:0] nlo,
                          output int unsigned cyc);
        longint sa, sb, q, r;
        logic [63:0] p;
        nhi = ohi;
        nlo = olo;
        cyc = 0;
        sa  = $signed(a);
        sb  = $signed(b);
        case (o)
            3'd1: begin p = 64'(sa * sb); nhi = p[63:32]; nlo = p[31:0]; cyc = 5; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; nhi = p[63:32]; nlo = p[31:0]; cyc = 5; end
            3'd3: begin
                cyc = 10;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    nlo = q[31:0];
                    nhi = r[31:0];
                end
            end
            3'd4: begin
                cyc = 10;
                if (b != 0) begin nlo = a / b; nhi = a % b; end
            end
            3'd5: nhi = a;
            3'd6: nlo = a;
            default: ;
        endcase
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(lo), 64'(m_lo));
    endtask

    // Count busy cycles starting from the current (negedge) sample.
    task automatic count_busy(output int unsigned n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Issue one op at the next posedge and follow it to completion.
    task automatic md(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int unsigned cyc, n;
        ref_md(o, a, b, m_hi, m_lo, eh, el, cyc);
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        if (cyc != 0) begin
            check({tag, "_busy1"}, 64'(busy), 64'd1);
            check_regs({tag, "_hold"});
            count_busy(n);
            check({tag, "_busylen"}, 64'(n), 64'(cyc));
        end else begin
            check({tag, "_nobusy"}, 64'(busy), 64'd0);
        end
        m_hi = eh;
        m_lo = el;
        check_regs(tag);
    endtask

    initial begin
        int unsigned n;
        logic [31:0] eh, el;
        int unsigned cyc;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
        srcA = '0; srcB = '0; readHi = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check_regs("rst");
        check("rst_rd", 64'(readData), 64'd0);

        md("mult", 3'd1, 32'hFFFFFFFE, 32'd3);
        check("mult_hi_c", 64'(hi), 64'hFFFFFFFF);
        check("mult_lo_c", 64'(lo), 64'hFFFFFFFA);
        md("multu", 3'd2, 32'hFFFFFFFE, 32'd3);
        check("multu_hi_c", 64'(hi), 64'h00000002);
        md("div", 3'd3, 32'hFFFFFFF9, 32'd2);
        check("div_lo_c", 64'(lo), 64'hFFFFFFFD);
        check("div_hi_c", 64'(hi), 64'hFFFFFFFF);
        md("divu", 3'd4, 32'd7, 32'd2);
        check("divu_c", 64'({hi, lo}), {32'd1, 32'd3});
        md("mthi", 3'd5, 32'h11, 32'd0);
        md("mtlo", 3'd6, 32'h22, 32'd0);
        md("div0", 3'd3, 32'd1234, 32'd0);
        check("div0_c", 64'({hi, lo}), {32'h11, 32'h22});
        md("divovf", 3'd3, 32'h80000000, 32'hFFFFFFFF);
        check("divovf_c", 64'({hi, lo}), {32'h0, 32'h80000000});

        // MULT then an MTLO attempted while busy: must be ignored.
        op = 3'd1; srcA = 32'd2; srcB = 32'd3; start = 1'b1;
        @(negedge clk);
        op = 3'd6; srcA = 32'h55;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        count_busy(n);
        check("busystart_len", 64'(n), 64'd4);
        m_hi = 32'd0; m_lo = 32'd6;
        check_regs("busystart");

        // Flushed start is dropped.
        op = 3'd1; srcA = 32'd9; srcB = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; op = 3'd0;
        check("flush_busy", 64'(busy), 64'd0);
        check_regs("flush");

        // Reset during the third busy cycle of a DIV.
        op = 3'd3; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("rstmid_busy", 64'(busy), 64'd0);
        check_regs("rstmid");
        repeat (12) @(negedge clk);
        check_regs("rstmid_late");

        // Back-to-back MULT then DIV with readHi toggling.
        op = 3'd1; srcA = 32'h12345; srcB = 32'hFFFF0001; start = 1'b1;
        ref_md(3'd1, srcA, srcB, m_hi, m_lo, eh, el, cyc);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        count_busy(n);
        check("b2b_mult_len", 64'(n), 64'd5);
        m_hi = eh; m_lo = el;
        check_regs("b2b_mult");
        op = 3'd4; srcA = 32'd1000; srcB = 32'd33; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        readHi = 1'b1; #1;
        check("rd_hi", 64'(readData), 64'(m_hi));
        readHi = 1'b0; #1;
        check("rd_lo", 64'(readData), 64'(m_lo));
        check_regs("b2b_during");
        @(negedge clk);
        count_busy(n);
        check("b2b_div_len", 64'(n + 1), 64'd10);
        m_hi = 32'd10; m_lo = 32'd30;
        check_regs("b2b_div");

        // Random ops against the model.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            logic [2:0]  ro;
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 100));
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
                default: rb = $urandom;
            endcase
            md("rand", ro, ra, rb);
            readHi = ~readHi; #1;
            check("rand_rd", 64'(readData), 64'(readHi ? m_hi : m_lo));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
